// File: rtl/chronos_pkg.sv
// Shared definitions for the fetch stage: datapath width, the NOP encoding
// used as the idle/trap instruction, and the fetch FSM state type.
package chronos_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_out_reg.sv
// Output holding register for the fetch stage: instruction, PC, valid flag
// and (with FETCH_MISALIGN_TRAP_EN) the misalign flag presented to decode.
// A load wins over a clear in the same cycle so a consume can be followed
// immediately by a new trap entry.
module fetch_out_reg
    import chronos_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    input  logic            i_misalign,
    output logic            o_misalign,
`endif
    output logic            o_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc
);

    logic            r_valid;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            r_misalign;
`endif

    // Hold the fetched word until loaded again; clear only drops the flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misalign <= i_misalign;
`endif
        end else if (i_clear) begin
            r_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign o_misalign = r_misalign;
`endif

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: accepts a PC, issues a single outstanding memory
// read, and holds the returned instruction until decode consumes it. A flush
// discards buffered output and drains any in-flight response.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned PC trap).
module instr_fetch
    import chronos_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    input  logic        flush
);

    fetch_state_t    r_state;
    fetch_state_t    w_next_state;
    logic [XLEN-1:0] r_imem_addr;
    logic            w_pc_ready;
    logic            w_accept;
    logic            w_addr_en;
    logic            w_load;
    logic            w_clear;
    logic [XLEN-1:0] w_load_instr;
    logic [XLEN-1:0] w_load_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            w_load_mis;
`endif

    assign w_pc_ready = !rst && !flush &&
                        ((r_state == IDLE) || ((r_state == HOLD) && out_ready));
    assign w_accept   = pc_valid && w_pc_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request address is captured on accept and held while the request is open.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_imem_addr <= '0;
        end else if (w_addr_en) begin
            r_imem_addr <= pc_in;
        end
    end

    // Next-state and output-register control.
    always_comb begin
        w_next_state = r_state;
        w_addr_en    = 1'b0;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_load_instr = imem_rdata;
        w_load_pc    = r_imem_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
        w_load_mis   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_clear = 1'b1;
                end
            end
            WAIT: begin
                if (flush) begin
                    w_next_state = imem_ack ? IDLE : DRAIN;
                end else if (imem_ack) begin
                    w_load       = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (flush || out_ready) begin
                    w_clear      = 1'b1;
                    w_next_state = IDLE;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase

        // Accept is only possible in IDLE or a consumed HOLD, never under flush,
        // so it overrides the per-state decision above.
        if (w_accept) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (pc_in[1:0] != 2'b00) begin
                w_load       = 1'b1;
                w_load_instr = NOP_INSTR;
                w_load_pc    = pc_in;
                w_load_mis   = 1'b1;
                w_next_state = HOLD;
            end else
`endif
            begin
                w_addr_en    = 1'b1;
                w_next_state = WAIT;
            end
        end
    end

    fetch_out_reg u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_clear    (w_clear),
        .i_instr    (w_load_instr),
        .i_pc       (w_load_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .i_misalign (w_load_mis),
        .o_misalign (misalign),
`endif
        .o_valid    (out_valid),
        .o_instr    (out_instr),
        .o_pc       (out_pc)
    );

    assign pc_ready  = w_pc_ready;
    assign imem_req  = (r_state == WAIT) || (r_state == DRAIN);
    assign imem_addr = r_imem_addr;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table plus short
// hand-written sequences. Define FETCH_MISALIGN_TRAP_EN to cover the trap.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        flush;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_ready  (out_ready),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign   (misalign),
`endif
        .flush      (flush)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    typedef struct {
        logic        rst;
        logic        pc_valid;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] rdata;
        logic        out_ready;
        logic        flush;
        logic        e_prdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic pv, logic [31:0] pc, logic ack, logic [31:0] rd,
                                logic ordy, logic fl, logic e_prdy, logic e_req,
                                logic [31:0] e_addr, logic e_val, logic [31:0] e_instr,
                                logic [31:0] e_pc);
        vec_t v;
        v.rst = r; v.pc_valid = pv; v.pc = pc; v.ack = ack; v.rdata = rd;
        v.out_ready = ordy; v.flush = fl; v.e_prdy = e_prdy; v.e_req = e_req;
        v.e_addr = e_addr; v.e_val = e_val; v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] I0  = 32'h00500093;
    localparam logic [31:0] I4  = 32'h44444444;

    initial begin
        rst = 1'b1; pc_in = '0; pc_valid = 1'b0; imem_ack = 1'b0;
        imem_rdata = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);

        //              rst pv pc     ack rdata         ordy fl | prdy req addr   val instr pc
        tbl.push_back(mk(1, 0, 32'h0, 0, 32'h0,        0, 0,   0, 0, 32'h0,  0, NOP, 32'h0));  // 0 reset
        tbl.push_back(mk(0, 1, 32'h0, 0, 32'h0,        1, 0,   1, 0, 32'h0,  0, NOP, 32'h0));  // 1 accept pc 0
        tbl.push_back(mk(0, 0, 32'h0, 1, I0,           1, 0,   0, 1, 32'h0,  0, NOP, 32'h0));  // 2 ack
        tbl.push_back(mk(0, 1, 32'h4, 0, 32'h0,        0, 0,   0, 0, 32'h0,  1, I0,  32'h0));  // 3 HOLD stall
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, 32'h4, 1, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0, 1, I0, 32'h0));  // 4-7 stall, stray ack
        tbl.push_back(mk(0, 1, 32'h4, 0, 32'h0,        1, 0,   1, 0, 32'h0,  1, I0,  32'h0));  // 8 release+accept
        tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0,        1, 0,   0, 1, 32'h4,  0, I0,  32'h0));  // 9 WAIT
        tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0,        1, 1,   0, 1, 32'h4,  0, I0,  32'h0));  // 10 flush in WAIT
        tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0,        1, 0,   0, 1, 32'h4,  0, I0,  32'h0));  // 11 DRAIN
        tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0,        1, 0,   0, 1, 32'h4,  0, I0,  32'h0));  // 12 DRAIN
        tbl.push_back(mk(0, 0, 32'h0, 1, 32'h11111111, 1, 0,   0, 1, 32'h4,  0, I0,  32'h0));  // 13 late ack dropped
        tbl.push_back(mk(0, 1, 32'h8, 0, 32'h0,        1, 0,   1, 0, 32'h4,  0, I0,  32'h0));  // 14 IDLE accept 8
        tbl.push_back(mk(0, 1, 32'hC, 1, 32'h22222222, 1, 1,   0, 1, 32'h8,  0, I0,  32'h0));  // 15 flush+ack
        tbl.push_back(mk(0, 1, 32'hC, 0, 32'h0,        1, 0,   1, 0, 32'h8,  0, I0,  32'h0));  // 16 accept C
        tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0,        1, 0,   0, 1, 32'hC,  0, I0,  32'h0));  // 17 WAIT
        tbl.push_back(mk(1, 0, 32'h0, 0, 32'h0,        1, 0,   0, 1, 32'hC,  0, I0,  32'h0));  // 18 rst mid-WAIT
        tbl.push_back(mk(0, 0, 32'h0, 1, 32'h33333333, 1, 0,   1, 0, 32'h0,  0, NOP, 32'h0));  // 19 late ack ignored
        tbl.push_back(mk(0, 1, 32'h10, 0, 32'h0,       1, 0,   1, 0, 32'h0,  0, NOP, 32'h0));  // 20 accept 10
        tbl.push_back(mk(0, 0, 32'h0, 1, I4,           0, 0,   0, 1, 32'h10, 0, NOP, 32'h0));  // 21 ack
        tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0,        0, 1,   0, 0, 32'h10, 1, I4,  32'h10)); // 22 flush in HOLD
        tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0,        0, 0,   1, 0, 32'h10, 0, I4,  32'h10)); // 23 IDLE

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; pc_valid = tbl[i].pc_valid; pc_in = tbl[i].pc;
            imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
            out_ready = tbl[i].out_ready; flush = tbl[i].flush;
            #1;
            chk($sformatf("r%0d pc_ready", i),  {31'b0, pc_ready},  {31'b0, tbl[i].e_prdy});
            chk($sformatf("r%0d imem_req", i),  {31'b0, imem_req},  {31'b0, tbl[i].e_req});
            chk($sformatf("r%0d imem_addr", i), imem_addr,          tbl[i].e_addr);
            chk($sformatf("r%0d out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_val});
            chk($sformatf("r%0d out_instr", i), out_instr,          tbl[i].e_instr);
            chk($sformatf("r%0d out_pc", i),    out_pc,             tbl[i].e_pc);
        end

        // Delayed ack with a bounded wait for the output.
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; imem_ack = 1'b0; out_ready = 1'b0;
        pc_valid = 1'b1; pc_in = 32'h20;
        #1 chk("seq accept pc_ready", {31'b0, pc_ready}, 32'd1);
        @(negedge clk);
        pc_valid = 1'b0;
        #1 chk("seq req addr", imem_addr, 32'h20);
        @(negedge clk);
        #1 chk("seq req held", {31'b0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h00A00113;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = '0;
        #1;
        for (int k = 0; k < 8 && !out_valid; k++) begin
            @(negedge clk); #1;
        end
        chk("seq out_valid", {31'b0, out_valid}, 32'd1);
        chk("seq out_instr", out_instr, 32'h00A00113);
        chk("seq out_pc", out_pc, 32'h20);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1 chk("seq consumed", {31'b0, out_valid}, 32'd0);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned PC traps straight to HOLD with no memory request.
        @(negedge clk);
        pc_valid = 1'b1; pc_in = 32'h6;
        #1 chk("mis pc_ready", {31'b0, pc_ready}, 32'd1);
        @(negedge clk);
        pc_valid = 1'b0;
        #1;
        chk("mis imem_req", {31'b0, imem_req}, 32'd0);
        chk("mis out_valid", {31'b0, out_valid}, 32'd1);
        chk("mis flag", {31'b0, misalign}, 32'd1);
        chk("mis out_instr", out_instr, NOP);
        chk("mis out_pc", out_pc, 32'h6);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("mis cleared", {31'b0, misalign}, 32'd0);
        chk("mis valid cleared", {31'b0, out_valid}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
